// File: rtl/datamem_sized.sv
// Byte-addressable big-endian data memory with byte/half/word access, load extension,
// range/alignment checking and a registered one-cycle ack. Build option: DATAMEM_MISALIGN_TRAP_EN.
module datamem_sized #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_BYTES = 256,
    parameter bit INIT_RAMP   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              is_uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              ack,
    output logic              err,
    output logic [31:0]       rdata
);

    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_W:0] LAST_BYTE = (ADDR_W+1)'(DEPTH_BYTES - 1);

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    size_e             size_s;
    logic              accept;
    logic              size_bad;
    logic              misalign;
    logic              out_of_range;
    logic              bad;
    logic              store_en;
    logic [1:0]        nbytes_m1;
    logic [ADDR_W-1:0] eff_addr;
    logic [ADDR_W:0]   last_addr;
    logic [IDX_W-1:0]  idx;
    logic [7:0]        wbyte [4];
    logic [7:0]        rbyte [4];
    logic [7:0]        mem_rd [DEPTH_BYTES];
    logic [31:0]       load_val;

    logic              ack_d,   ack_q;
    logic              err_d,   err_q;
    logic [31:0]       rdata_d, rdata_q;

    assign size_s = size_e'(size);

    // Request decode: size, effective (possibly force-aligned) address and error flags.
    // NOTE: every signal gets a default at the top of always_comb so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        accept    = req & rst_n;
        size_bad  = 1'b0;
        nbytes_m1 = 2'd0;
        misalign  = 1'b0;
        eff_addr  = addr;
        unique case (size_s)
            SZ_BYTE: nbytes_m1 = 2'd0;
            SZ_HALF: nbytes_m1 = 2'd1;
            SZ_WORD: nbytes_m1 = 2'd3;
            default: size_bad  = 1'b1;
        endcase
`ifdef DATAMEM_MISALIGN_TRAP_EN
        misalign = ((size_s == SZ_HALF) && addr[0]) ||
                   ((size_s == SZ_WORD) && (addr[1:0] != 2'b00));
`else
        if (size_s == SZ_HALF) eff_addr[0]   = 1'b0;
        if (size_s == SZ_WORD) eff_addr[1:0] = 2'b00;
`endif
        // One extra bit keeps the end address from wrapping near the top of the space.
        last_addr    = {1'b0, eff_addr} + (ADDR_W+1)'(nbytes_m1);
        out_of_range = last_addr > LAST_BYTE;
        bad          = size_bad | out_of_range | misalign;
        store_en     = accept & we & ~bad;
        idx          = eff_addr[IDX_W-1:0];
    end

    // Store data split into big-endian lanes: lane 0 lands at idx, lane k at idx+k.
    always_comb begin
        for (int k = 0; k < 4; k++) wbyte[k] = 8'h00;
        unique case (size_s)
            SZ_BYTE: wbyte[0] = wdata[7:0];
            SZ_HALF: begin
                wbyte[0] = wdata[15:8];
                wbyte[1] = wdata[7:0];
            end
            SZ_WORD: begin
                wbyte[0] = wdata[31:24];
                wbyte[1] = wdata[23:16];
                wbyte[2] = wdata[15:8];
                wbyte[3] = wdata[7:0];
            end
            default: ;
        endcase
    end

    // Index arithmetic wraps inside the array; a wrapped read is only possible on an
    // out-of-range request, whose data is discarded.
    always_comb begin
        for (int k = 0; k < 4; k++) rbyte[k] = mem_rd[idx + IDX_W'(k)];
    end

    always_comb begin
        load_val = 32'h0000_0000;
        unique case (size_s)
            SZ_BYTE: load_val = {{24{~is_uns & rbyte[0][7]}}, rbyte[0]};
            SZ_HALF: load_val = {{16{~is_uns & rbyte[0][7]}}, rbyte[0], rbyte[1]};
            SZ_WORD: load_val = {rbyte[0], rbyte[1], rbyte[2], rbyte[3]};
            default: ;
        endcase
    end

    for (genvar i = 0; i < DEPTH_BYTES; i++) begin : g_mem
        logic [7:0]       byte_q = INIT_RAMP ? 8'(i) : 8'h00;
        logic [7:0]       byte_d;
        logic [IDX_W-1:0] lane;

        always_comb begin
            lane   = IDX_W'(i) - idx;
            byte_d = byte_q;
            if (store_en && (lane <= IDX_W'(nbytes_m1))) byte_d = wbyte[lane[1:0]];
        end

        // NOTE: storage has no reset branch; contents survive rst_n and keep their
        // power-up value until written.
        always_ff @(posedge clk) begin
            byte_q <= byte_d;
        end

        assign mem_rd[i] = byte_q;
    end

    always_comb begin
        ack_d   = accept;
        err_d   = accept & bad;
        rdata_d = (accept && !we && !bad) ? load_val : 32'h0000_0000;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
        end else begin
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign ready = rst_n;
    assign ack   = ack_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_datamem_sized.sv
// Directed scoreboard bench for datamem_sized: each step drives one request, queues the
// expected response and compares it one clock later. Tracks DATAMEM_MISALIGN_TRAP_EN.
module tb_datamem_sized;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        is_uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    resp_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 clk = ~clk;

    datamem_sized #(
        .ADDR_W     (32),
        .DEPTH_BYTES(256),
        .INIT_RAMP  (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .we    (we),
        .size  (size),
        .is_uns(is_uns),
        .addr  (addr),
        .wdata (wdata),
        .ready (ready),
        .ack   (ack),
        .err   (err),
        .rdata (rdata)
    );

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic r, input logic w,
                        input logic [1:0] sz, input logic uns, input logic [31:0] a,
                        input logic [31:0] wd, input logic e_ack, input logic e_err,
                        input logic [31:0] e_rd);
        resp_t got;
        resp_t expv;
        rst_n  = rst;
        req    = r;
        we     = w;
        size   = sz;
        is_uns = uns;
        addr   = a;
        wdata  = wd;
        exp_q.push_back('{e_ack, e_err, e_rd});
        @(posedge clk);
        #1;
        expv = exp_q.pop_front();
        got  = '{ack, err, rdata};
        check(tag, got, expv);
        check({tag, "_ready"}, {33'b0, ready}, {33'b0, rst});
    endtask

    task automatic ld(input string tag, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic e_err, input logic [31:0] e_rd);
        step(tag, 1'b1, 1'b1, 1'b0, sz, uns, a, 32'h0, 1'b1, e_err, e_rd);
    endtask

    task automatic st(input string tag, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input logic e_err);
        step(tag, 1'b1, 1'b1, 1'b1, sz, 1'b0, a, wd, 1'b1, e_err, 32'h0);
    endtask

    task automatic idle(input string tag, input logic rst);
        step(tag, rst, 1'b0, 1'b0, SZ_B, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        // Reset cycles: a store presented under reset must not ack nor write.
        step("rst_store", 1'b0, 1'b1, 1'b1, SZ_B, 1'b0, 32'h40, 32'hAA, 1'b0, 1'b0, 32'h0);
        idle("rst_idle", 1'b0);
        idle("idle0", 1'b1);

        ld("lw_04", SZ_W, 1'b0, 32'h04, 1'b0, 32'h0405_0607);
        ld("lbu_40_after_rst", SZ_B, 1'b1, 32'h40, 1'b0, 32'h0000_0040);

        st("sb_10", SZ_B, 32'h10, 32'h0000_0080, 1'b0);
        ld("lb_10", SZ_B, 1'b0, 32'h10, 1'b0, 32'hFFFF_FF80);
        ld("lbu_10", SZ_B, 1'b1, 32'h10, 1'b0, 32'h0000_0080);

        st("sh_20", SZ_H, 32'h20, 32'h1234_BEEF, 1'b0);
        ld("lw_20", SZ_W, 1'b0, 32'h20, 1'b0, 32'hBEEF_2223);
        ld("lh_20", SZ_H, 1'b0, 32'h20, 1'b0, 32'hFFFF_BEEF);
        ld("lhu_20", SZ_H, 1'b1, 32'h20, 1'b0, 32'h0000_BEEF);
        idle("idle1", 1'b1);

        st("sw_60", SZ_W, 32'h60, 32'h1122_3344, 1'b0);
        ld("lw_60", SZ_W, 1'b1, 32'h60, 1'b0, 32'h1122_3344);
        ld("lhu_62", SZ_H, 1'b1, 32'h62, 1'b0, 32'h0000_3344);
        ld("lb_61", SZ_B, 1'b0, 32'h61, 1'b0, 32'h0000_0022);

        ld("lw_fc", SZ_W, 1'b0, 32'hFC, 1'b0, 32'hFCFD_FEFF);
        ld("lw_100", SZ_W, 1'b0, 32'h100, 1'b1, 32'h0);
        ld("lb_hi_addr", SZ_B, 1'b0, 32'h8000_0004, 1'b1, 32'h0);
        ld("lw_top", SZ_W, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0);
        st("sb_hi_addr", SZ_B, 32'h8000_0010, 32'h99, 1'b1);
        ld("lbu_10_kept", SZ_B, 1'b1, 32'h10, 1'b0, 32'h0000_0080);

`ifdef DATAMEM_MISALIGN_TRAP_EN
        st("sw_fe", SZ_W, 32'hFE, 32'hDEAD_BEEF, 1'b1);
        ld("lw_fc_kept", SZ_W, 1'b0, 32'hFC, 1'b0, 32'hFCFD_FEFF);
        ld("lb_ff", SZ_B, 1'b0, 32'hFF, 1'b0, 32'hFFFF_FFFF);
        ld("lh_ff", SZ_H, 1'b0, 32'hFF, 1'b1, 32'h0);
        ld("lw_05", SZ_W, 1'b0, 32'h05, 1'b1, 32'h0);
        ld("lh_07", SZ_H, 1'b0, 32'h07, 1'b1, 32'h0);
`else
        st("sw_fe", SZ_W, 32'hFE, 32'hDEAD_BEEF, 1'b0);
        ld("lw_fc_new", SZ_W, 1'b0, 32'hFC, 1'b0, 32'hDEAD_BEEF);
        ld("lb_ff", SZ_B, 1'b0, 32'hFF, 1'b0, 32'hFFFF_FFEF);
        ld("lh_ff", SZ_H, 1'b0, 32'hFF, 1'b0, 32'hFFFF_BEEF);
        ld("lw_05", SZ_W, 1'b0, 32'h05, 1'b0, 32'h0405_0607);
        ld("lh_07", SZ_H, 1'b0, 32'h07, 1'b0, 32'h0000_0607);
`endif

        // A pending ack is dropped by reset; a store under reset leaves memory alone.
        ld("lw_08_pre_rst", SZ_W, 1'b0, 32'h08, 1'b0, 32'h0809_0A0B);
        step("rst_cancel", 1'b0, 1'b1, 1'b1, SZ_B, 1'b0, 32'h44, 32'hAA, 1'b0, 1'b0, 32'h0);
        idle("post_rst", 1'b1);
        ld("lbu_44_kept", SZ_B, 1'b1, 32'h44, 1'b0, 32'h0000_0044);

        ld("ld_rsvd", SZ_R, 1'b0, 32'h00, 1'b1, 32'h0);
        st("st_rsvd", SZ_R, 32'h50, 32'hFFFF_FFFF, 1'b1);
        ld("lbu_50_kept", SZ_B, 1'b1, 32'h50, 1'b0, 32'h0000_0050);
        idle("idle_end", 1'b1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
